// File: rtl/joy_serial_tx.sv
// ============================================================================
// joy_serial_tx
//
// Presents two 12-button controller snapshots to an external reader as a
// 24-bit serial frame.
//
// The reader pulls joy_load low to latch the buttons and then clocks the
// frame out with joy_clk. Both reader signals are asynchronous to clk12 and
// are resynchronised before use. While the synchronised load is low, the
// shift register reloads on every clk12 cycle. Each synchronised joy_clk
// rising edge then moves the frame forward by one bit, and the register
// fills with 1s from the bottom. After 24 shifts the line stays high until
// the next load.
//
// Frame order, first bit out to last:
//   joy1[8,6,5,4,3,2,1,0], joy2[8,6,5,4,3,2,1,0],
//   joy2[10,11,9,7], joy1[10,11,9,7]
//
// Ports
//   clk12       in   1   system clock, 12 MHz, rising-edge
//   reset       in   1   asynchronous, active-high reset
//   joy_clk     in   1   reader shift clock (async, ~224 kHz)
//   joy_load    in   1   reader load strobe (async, active low)
//   joy1        in  12   player-1 buttons, active low (1 = released)
//   joy2        in  12   player-2 buttons, active low (1 = released)
//   joy_data    out  1   serial data to the reader (shift-register MSB)
//   frame_done  out  1   one-cycle pulse after the 24th shift of a frame
//   busy        out  1   high from a load until the 24th shift
//
// Configuration macro
//   JOY_SERIAL_TX_GLITCH_FILTER_EN
//     When defined, a joy_clk level change is accepted only after three
//     identical consecutive synchronised samples. This rejects short
//     glitches. Worst-case shift latency becomes 6 clk12 cycles instead of 4.
// ============================================================================

module joy_serial_tx (
    input  logic        clk12,
    input  logic        reset,
    input  logic        joy_clk,
    input  logic        joy_load,
    input  logic [11:0] joy1,
    input  logic [11:0] joy2,
    output logic        joy_data,
    output logic        frame_done,
    output logic        busy
);

    localparam logic [4:0] FRAME_LEN  = 5'd24;
    localparam logic [4:0] LAST_SHIFT = 5'd23;

    typedef enum logic {
        ST_IDLE,
        ST_FRAME
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        clk_s1;
    logic        clk_s2;
    logic        ld_s1;
    logic        ld_s2;
    logic        clk_rise;
    logic        load_act;
    logic        shift_act;
    logic [23:0] frame_word;
    logic [23:0] shreg;
    logic [4:0]  shift_cnt;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers. Idle level is 1 for both, so reset puts the
    // synchronisers in the "not loading" state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            ld_s1  <= 1'b1;
            ld_s2  <= 1'b1;
        end else begin
            clk_s1 <= joy_clk;
            clk_s2 <= clk_s1;
            ld_s1  <= joy_load;
            ld_s2  <= ld_s1;
        end
    end

`ifdef JOY_SERIAL_TX_GLITCH_FILTER_EN
    // ------------------------------------------------------------------------
    // Glitch filter. clk_filt follows the synchronised clock only after
    // three matching samples (clk_s2, clk_h1, clk_h2). The rise is flagged
    // combinationally in the same cycle the filter would accept a new high
    // level. This keeps the external-edge-to-shift latency at 5 cycles.
    // ------------------------------------------------------------------------
    logic clk_h1;
    logic clk_h2;
    logic clk_filt;

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            clk_h1   <= 1'b1;
            clk_h2   <= 1'b1;
            clk_filt <= 1'b1;
        end else begin
            clk_h1 <= clk_s2;
            clk_h2 <= clk_h1;
            if ((clk_s2 == clk_h1) && (clk_h1 == clk_h2)) begin
                clk_filt <= clk_s2;
            end
        end
    end

    assign clk_rise = clk_s2 & clk_h1 & clk_h2 & ~clk_filt;
`else
    // ------------------------------------------------------------------------
    // Unfiltered edge detect on the synchronised clock. A single-cycle high
    // sample is treated as a genuine edge.
    // ------------------------------------------------------------------------
    logic clk_prev;

    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            clk_prev <= 1'b1;
        end else begin
            clk_prev <= clk_s2;
        end
    end

    assign clk_rise = clk_s2 & ~clk_prev;
`endif

    // Load is level-sensitive and always wins over a concurrent shift.
    assign load_act  = ~ld_s2;
    assign shift_act = ld_s2 & clk_rise;

    // ------------------------------------------------------------------------
    // Parallel-load image. Bit 23 is sent first.
    // ------------------------------------------------------------------------
    always_comb begin
        frame_word = {
            joy1[8], joy1[6], joy1[5], joy1[4],
            joy1[3], joy1[2], joy1[1], joy1[0],
            joy2[8], joy2[6], joy2[5], joy2[4],
            joy2[3], joy2[2], joy2[1], joy2[0],
            joy2[10], joy2[11], joy2[9], joy2[7],
            joy1[10], joy1[11], joy1[9], joy1[7]
        };
    end

    // ------------------------------------------------------------------------
    // Shift register. Shifting in 1s makes an exhausted frame read as all
    // released buttons, with no wrap-around.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            shreg <= '1;
        end else if (load_act) begin
            shreg <= frame_word;
        end else if (shift_act) begin
            shreg <= {shreg[22:0], 1'b1};
        end
    end

    assign joy_data = shreg[23];

    // ------------------------------------------------------------------------
    // Shift counter, saturating at FRAME_LEN.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            shift_cnt <= '0;
        end else if (load_act) begin
            shift_cnt <= '0;
        end else if (shift_act && (shift_cnt != FRAME_LEN)) begin
            shift_cnt <= shift_cnt + 5'd1;
        end
    end

    // frame_done is qualified by ST_FRAME. Shifts clocked in after reset
    // with no load therefore never report a completed frame.
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= shift_act && (state == ST_FRAME) &&
                          (shift_cnt == LAST_SHIFT);
        end
    end

    // ------------------------------------------------------------------------
    // Frame FSM: state register, next-state logic, outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk12 or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (load_act) begin
            state_nxt = ST_FRAME;
        end else if ((state == ST_FRAME) && shift_act &&
                     (shift_cnt == LAST_SHIFT)) begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        busy = 1'b0;
        if (state == ST_FRAME) begin
            busy = 1'b1;
        end
    end

endmodule
